// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two buffered requesters (ALU, load) share one
// write port, with round-robin grants, per-register pending tracking and flush.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        flush,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic [31:0] pending
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {
    LAST_A,
    LAST_B
  } last_e;

  // Per-requester FIFO storage; index 0 is A, index 1 is B.
  logic [4:0]       q_addr   [2][DEPTH];
  logic [4:0]       q_addr_n [2][DEPTH];
  logic [31:0]      q_data   [2][DEPTH];
  logic [31:0]      q_data_n [2][DEPTH];
  logic [DEPTH-1:0] q_vld    [2];
  logic [DEPTH-1:0] q_vld_n  [2];
  logic [PW-1:0]    q_rd     [2];
  logic [PW-1:0]    q_rd_n   [2];
  logic [PW-1:0]    q_wr     [2];
  logic [PW-1:0]    q_wr_n   [2];

  logic [31:0] pend_q [2];
  logic [31:0] pend_n [2];
  logic [31:0] pending_q;
  logic [31:0] pending_n;

  logic        we_q;
  logic        we_n;
  logic [4:0]  wa_q;
  logic [4:0]  wa_n;
  logic [31:0] wd_q;
  logic [31:0] wd_n;
  last_e       last_q;
  last_e       last_n;

  logic        a_rdy;
  logic        b_rdy;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  acc;
  logic [1:0]  cand;
  logic [1:0]  grant;
  logic [4:0]  in_addr   [2];
  logic [31:0] in_data   [2];
  logic [4:0]  head_addr [2];
  logic [31:0] head_data [2];
  logic        sel_valid;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    q_addr_n  = q_addr;
    q_data_n  = q_data;
    q_vld_n   = q_vld;
    q_rd_n    = q_rd;
    q_wr_n    = q_wr;
    pend_n[0] = '0;
    pend_n[1] = '0;

    in_addr[0] = a_addr;
    in_addr[1] = b_addr;
    in_data[0] = a_data;
    in_data[1] = b_data;

    for (int unsigned s = 0; s < 2; s++) begin
      empty[s] = ~|q_vld[s[0]];
      full[s]  = &q_vld[s[0]];
    end

    // A side is blocked by B-owned pending registers and vice versa, so the two
    // sides never hold writes to the same register; A wins a same-cycle collision.
    a_rdy = !rst && !flush && !full[0] && !pend_q[1][a_addr];
    b_rdy = !rst && !flush && !full[1] && !pend_q[0][b_addr] &&
            !(a_valid && a_rdy && (a_addr == b_addr));
    acc[0] = a_valid && a_rdy;
    acc[1] = b_valid && b_rdy;

    // An empty FIFO offers its incoming write directly, giving one-cycle latency.
    for (int unsigned s = 0; s < 2; s++) begin
      cand[s]           = !flush && (!empty[s] || acc[s]);
      head_addr[s[0]]   = empty[s] ? in_addr[s[0]] : q_addr[s[0]][q_rd[s[0]]];
      head_data[s[0]]   = empty[s] ? in_data[s[0]] : q_data[s[0]][q_rd[s[0]]];
    end

    grant = '0;
    if (cand[0] && cand[1]) begin
      if (last_q == LAST_B) grant[0] = 1'b1;
      else                  grant[1] = 1'b1;
    end else begin
      grant = cand;
    end

    sel_valid = |grant;
    sel_addr  = grant[1] ? head_addr[1] : head_addr[0];
    sel_data  = grant[1] ? head_data[1] : head_data[0];
    last_n    = grant[1] ? LAST_B : (grant[0] ? LAST_A : last_q);

    we_n = sel_valid && (sel_addr != '0);
    wa_n = we_n ? sel_addr : wa_q;
    wd_n = we_n ? sel_data : wd_q;

    for (int unsigned s = 0; s < 2; s++) begin
      if (flush) begin
        q_vld_n[s[0]] = '0;
        q_rd_n[s[0]]  = '0;
        q_wr_n[s[0]]  = '0;
      end else begin
        if (grant[s] && !empty[s]) begin
          q_vld_n[s[0]][q_rd[s[0]]] = 1'b0;
          q_rd_n[s[0]]              = q_rd[s[0]] + 1'b1;
        end
        if (acc[s] && !(grant[s] && empty[s])) begin
          q_addr_n[s[0]][q_wr[s[0]]] = in_addr[s[0]];
          q_data_n[s[0]][q_wr[s[0]]] = in_data[s[0]];
          q_vld_n[s[0]][q_wr[s[0]]]  = 1'b1;
          q_wr_n[s[0]]               = q_wr[s[0]] + 1'b1;
        end
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (q_vld_n[s[0]][i[PW-1:0]]) pend_n[s[0]][q_addr_n[s[0]][i[PW-1:0]]] = 1'b1;
      end
      if (we_n && grant[s]) pend_n[s[0]][sel_addr] = 1'b1;
      pend_n[s[0]][0] = 1'b0;
    end

    pending_n = pend_n[0] | pend_n[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld     <= '{default: '0};
      q_rd      <= '{default: '0};
      q_wr      <= '{default: '0};
      pend_q    <= '{default: '0};
      pending_q <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      last_q    <= LAST_B;
    end else begin
      q_vld     <= q_vld_n;
      q_rd      <= q_rd_n;
      q_wr      <= q_wr_n;
      pend_q    <= pend_n;
      pending_q <= pending_n;
      we_q      <= we_n;
      wa_q      <= wa_n;
      wd_q      <= wd_n;
      last_q    <= last_n;
    end
  end

  always_ff @(posedge clk) begin
    q_addr <= q_addr_n;
    q_data <= q_data_n;
  end

  assign a_ready = a_rdy;
  assign b_ready = b_rdy;
  assign we      = we_q;
  assign wa      = {27'd0, wa_q};
  assign wd      = wd_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued per side
// on handshake and matched in order against every we pulse.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        flush;
  logic        we;
  logic [31:0] wa, wd, pending;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .flush(flush), .we(we), .wa(wa), .wd(wd), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_a[$];
  wr_t         exp_b[$];
  int          ret_side[$];
  int          ret_cyc[$];
  logic [31:0] rf_model [32];
  logic [4:0]  last_ret_addr;
  wr_t         mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  // Every write pulse must match the oldest outstanding write of one side.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      n_checks++;
      if (exp_a.size() > 0 && wa === {27'd0, exp_a[0].addr} && wd === exp_a[0].data) begin
        mon_e = exp_a.pop_front();
        ret_side.push_back(0);
        ret_cyc.push_back(cyc);
        last_ret_addr = mon_e.addr;
      end else if (exp_b.size() > 0 && wa === {27'd0, exp_b[0].addr} && wd === exp_b[0].data) begin
        mon_e = exp_b.pop_front();
        ret_side.push_back(1);
        ret_cyc.push_back(cyc);
        last_ret_addr = mon_e.addr;
      end else begin
        n_fail++;
        $display("FAIL retire: got wa=%h wd=%h, required head of A (%0d queued) or B (%0d queued)",
                 wa, wd, exp_a.size(), exp_b.size());
      end
      rf_model[wa[4:0]] = wd;
    end
  end

  task automatic sample_hs();
    wr_t e;
    if (a_valid && a_ready) begin
      e.addr = a_addr; e.data = a_data; exp_a.push_back(e);
    end
    if (b_valid && b_ready) begin
      e.addr = b_addr; e.data = b_data; exp_b.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2222_2222;
    @(negedge clk); @(negedge clk);
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", we); end
    n_checks++; if (wa !== 32'd0) begin n_fail++; $display("FAIL reset_wa: got %h required 0", wa); end
    n_checks++; if (wd !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h required 0", wd); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h required 0", pending); end
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b required 0", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b required 0", b_ready); end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_a_ready: got %b required 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_b_ready: got %b required 1", b_ready); end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", a_ready); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL single_pend_before: got %h required 0", pending); end
    sample_hs();
    @(negedge clk); a_valid = 1'b0; #1;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b required 1", we); end
    n_checks++; if (wa !== 32'd5) begin n_fail++; $display("FAIL single_wa: got %h required 5", wa); end
    n_checks++; if (wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wd: got %h required deadbeef", wd); end
    n_checks++; if (pending !== 32'h20) begin n_fail++; $display("FAIL single_pend: got %h required 20", pending); end
    @(negedge clk); #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL single_we_off: got %b required 0", we); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL single_pend_after: got %h required 0", pending); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000_1234;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b required 1", a_ready); end
    @(negedge clk); a_valid = 1'b0; #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b required 0", we); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL x0_pend: got %h required 0", pending); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready_after: got %b required 1", a_ready); end
    @(negedge clk); #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_we_late: got %b required 0", we); end
    n_checks++; if (wa !== 32'd5) begin n_fail++; $display("FAIL x0_wa_hold: got %h required 5", wa); end
    n_checks++; if (wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_wd_hold: got %h required deadbeef", wd); end
  endtask

  task automatic test_same_addr();
    ret_side.delete(); ret_cyc.delete();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA_0007;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB_0007;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL same_a_ready: got %b required 1", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL same_b_ready0: got %b required 0", b_ready); end
    sample_hs();
    @(negedge clk); a_valid = 1'b0; #1;
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL same_b_ready1: got %b required 0", b_ready); end
    sample_hs();
    @(negedge clk); #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL same_b_ready2: got %b required 1", b_ready); end
    sample_hs();
    @(negedge clk); b_valid = 1'b0; #1;
    n_checks++; if (wd !== 32'hBBBB_0007) begin n_fail++; $display("FAIL same_b_wd: got %h required bbbb0007", wd); end
    @(negedge clk); #1;
    n_checks++; if (rf_model[7] !== 32'hBBBB_0007) begin n_fail++; $display("FAIL same_final_x7: got %h required bbbb0007", rf_model[7]); end
    n_checks++;
    if (ret_side.size() != 2 || ret_side[0] != 0 || ret_side[1] != 1) begin
      n_fail++; $display("FAIL same_order: got %0d retirements, required A then B", ret_side.size());
    end
  endtask

  task automatic test_stream(input int na, input int nb, input bit check_alt, output int a_stalls);
    int ia = 0;
    int ib = 0;
    wr_t e;
    a_stalls = 0;
    ret_side.delete(); ret_cyc.delete();
    for (int c = 0; c < 100 && (ia < na || ib < nb); c++) begin
      @(negedge clk);
      a_valid = (ia < na); a_addr = 5'(1 + ia);  a_data = {16'hA0A0, 16'(ia)};
      b_valid = (ib < nb); b_addr = 5'(16 + ib); b_data = {16'hB0B0, 16'(ib)};
      #1;
      if (a_valid && a_ready) begin
        e.addr = a_addr; e.data = a_data; exp_a.push_back(e); ia++;
      end else if (a_valid) a_stalls++;
      if (b_valid && b_ready) begin
        e.addr = b_addr; e.data = b_data; exp_b.push_back(e); ib++;
      end
    end
    @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (ia != na || ib != nb) begin
      n_fail++; $display("FAIL stream_accept: got %0d/%0d accepted required %0d/%0d", ia, ib, na, nb);
    end
    for (int c = 0; c < 40 && (exp_a.size() > 0 || exp_b.size() > 0); c++) begin
      @(negedge clk); #2;
    end
    n_checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++; $display("FAIL stream_drain: got %0d/%0d outstanding required 0/0", exp_a.size(), exp_b.size());
    end
    n_checks++;
    if (ret_side.size() != na + nb) begin
      n_fail++; $display("FAIL stream_count: got %0d writes required %0d", ret_side.size(), na + nb);
    end
    if (check_alt) begin
      for (int i = 1; i < ret_side.size(); i++) begin
        n_checks++;
        if (ret_side[i] == ret_side[i-1] || ret_cyc[i] != ret_cyc[i-1] + 1) begin
          n_fail++;
          $display("FAIL stream_alternate[%0d]: got side %0d cycle %0d after side %0d cycle %0d, required other side next cycle",
                   i, ret_side[i], ret_cyc[i], ret_side[i-1], ret_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    test_stream(8, 8, 1'b1, stalls);
  endtask

  task automatic test_full();
    int stalls;
    test_stream(6, 12, 1'b0, stalls);
    n_checks++;
    if (stalls == 0) begin
      n_fail++; $display("FAIL full_backpressure: got %0d A stall cycles required at least 1", stalls);
    end
  endtask

  task automatic build_backlog();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'(1 + k);  a_data = {16'hF1A0, 16'(k)};
      b_valid = 1'b1; b_addr = 5'(17 + k); b_data = {16'hF1B0, 16'(k)};
      #1;
      sample_hs();
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_p;
    build_backlog();
    @(negedge clk);
    flush = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; b_valid = 1'b1; b_addr = 5'd25;
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL flush_a_ready: got %b required 0", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL flush_b_ready: got %b required 0", b_ready); end
    n_checks++;
    if (exp_a.size() + exp_b.size() != 3) begin
      n_fail++; $display("FAIL flush_backlog: got %0d buffered required 3", exp_a.size() + exp_b.size());
    end
    exp_p = 32'd1 << last_ret_addr;
    foreach (exp_a[i]) exp_p[exp_a[i].addr] = 1'b1;
    foreach (exp_b[i]) exp_p[exp_b[i].addr] = 1'b1;
    n_checks++; if (pending !== exp_p) begin n_fail++; $display("FAIL flush_pend_before: got %h required %h", pending, exp_p); end
    exp_a.delete(); exp_b.delete();
    @(negedge clk);
    flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %b required 0", we); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL flush_pend: got %h required 0", pending); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL flush_a_ready_after: got %b required 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL flush_b_ready_after: got %b required 1", b_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL flush_quiet[%0d]: got we=%b required 0", k, we); end
    end
  endtask

  task automatic test_rst_mid();
    build_backlog();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b required 0", we); end
    n_checks++; if (wa !== 32'd0) begin n_fail++; $display("FAIL rstmid_wa: got %h required 0", wa); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL rstmid_pend: got %h required 0", pending); end
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_a_ready: got %b required 0", a_ready); end
    exp_a.delete(); exp_b.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_a_ready_after: got %b required 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_b_ready_after: got %b required 1", b_ready); end
    ret_side.delete(); ret_cyc.delete();
    a_valid = 1'b1; a_addr = 5'd3;  a_data = 32'h0A0A_0003;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h0B0B_0014;
    #1;
    sample_hs();
    @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); #2;
    n_checks++;
    if (ret_side.size() != 2 || ret_side[0] != 0) begin
      n_fail++; $display("FAIL rstmid_priority: got %0d writes, required 2 with A first", ret_side.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_same_addr();
    test_back_to_back();
    test_full();
    test_flush();
    test_rst_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++; $display("FAIL final_outstanding: got %0d/%0d required 0/0", exp_a.size(), exp_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per requester buffer (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a_valid  input  1  requester A (ALU writeback) offers a write.
REQ-005 SHALL have port a_ready  output  1  A write accepted when a_valid&a_ready at clock edge.
REQ-006 SHALL have port a_addr  input  5  A destination register.
REQ-007 SHALL have port a_data  input  32  A write data.
REQ-008 SHALL have ports b_valid, b_ready, b_addr, b_data with the same direction, width and meaning for requester B (load writeback).
REQ-009 SHALL have port flush  input  1  synchronous discard of all buffered writes.
REQ-010 SHALL have port we  output  1  register-file write enable.
REQ-011 SHALL have port wa  output  32  register-file write address, zero-extended from 5 bits.
REQ-012 SHALL have port wd  output  32  register-file write data.
REQ-013 SHALL have port pending  output  32  bit r set while any buffered or issuing write targets xr.

Function
REQ-014 SHALL hold one FIFO of DEPTH {addr,data} entries per requester; writes retire in per-requester acceptance order.
REQ-015 a_ready SHALL be combinational: FIFO A not full AND pending bit a_addr not set by B-side entries AND not flush; b_ready likewise with roles swapped.
REQ-016 When a_valid, b_valid, a_addr==b_addr and both otherwise ready, SHALL accept A only (b_ready=0 that cycle).
REQ-017 Arbitration SHALL be round-robin between non-empty heads: one grant per cycle; last-granted requester loses a tie; after reset A has priority.
REQ-018 we/wa/wd SHALL be registered: a head granted at edge N drives we=1, wa, wd during cycle N+1 for exactly one cycle; entry popped at edge N.
REQ-019 Minimum latency SHALL be accept at edge N -> we=1 in cycle N+1 (bypass write-through when FIFO empty and granted).
REQ-020 A granted head with addr==0 SHALL be popped with we=0 (x0 writes discarded); it still consumes the grant slot.
REQ-021 pending SHALL be registered and equal the OR of one-hot addresses of all valid FIFO entries plus the entry driving we; bit 0 always 0.
REQ-022 Throughput SHALL be one retired write per cycle with both requesters streaming; neither requester starves (max wait one grant while other non-empty).
REQ-023 FIFO full: ready=0, no overwrite; FIFO empty: requester not considered for grant; pointers wrap modulo DEPTH.
REQ-024 Simultaneous accept and grant on the same FIFO SHALL be legal with occupancy unchanged.
REQ-025 flush SHALL at the next edge empty both FIFOs, clear pending, drive we=0, ignore that cycle's valids, and keep round-robin pointer.
REQ-026 wa SHALL hold last value when we=0; wd likewise.

Reset
REQ-027 While rst=1: both FIFOs empty, we=0, wa=0, wd=0, pending=0, priority to A, a_ready=b_ready=0.
REQ-028 Reset deassertion SHALL allow acceptance on the first subsequent edge; reset mid-transfer discards all buffered writes without a write pulse.

Verification
REQ-029 A writes x5=0xDEADBEEF, B idle -> cycle after accept: we=1, wa=5, wd=0xDEADBEEF; pending[5]=1 that cycle, 0 after.
REQ-030 A and B stream 8 writes each (distinct addrs) -> 16 writes in 16 consecutive cycles, alternating A,B,A,B..., per-side order preserved.
REQ-031 A and B same cycle both addr=7 -> A accepted, b_ready=0 until A's x7 write retires, then B's x7 write follows; final x7 = B data.
REQ-032 A writes x0=0x1234 -> no we pulse, a_ready remains 1, pending stays 0.
REQ-033 Hold regfile-side stalls absent, fill A to DEPTH with B granted continuously -> a_ready=0 at full, no entry lost or duplicated.
REQ-034 3 entries buffered, assert flush one cycle (also rst mid-operation) -> no further we pulses, pending=0, ready back to 1 next cycle.
